// File: rtl/data_mem_trace.sv
// Data-memory access tracer: windowed capture of bus loads/stores
// into a circular buffer, drained over a valid/ready port.
module data_mem_trace #(
    parameter int                ADDR_W = 32,
    parameter int                DATA_W = 32,
    parameter int                DEPTH  = 16,
    parameter logic [ADDR_W-1:0] WIN_LO = '0,
    parameter logic [ADDR_W-1:0] WIN_HI = {ADDR_W{1'b1}}
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      wdata,
    input  logic [DATA_W-1:0]      rdata,
    input  logic                   read,
    input  logic                   write,
    input  logic                   arm,
    input  logic                   disarm,
    input  logic                   clear,
    input  logic                   stop_on_full,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_wr,
    output logic                   out_rd,
    output logic [ADDR_W-1:0]      out_addr,
    output logic [DATA_W-1:0]      out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic [15:0]            drop_cnt,
    output logic [1:0]             state
);

    localparam int           AW     = $clog2(DEPTH);
    localparam logic [AW:0]  FULL_N = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        STOPPED = 2'd2
    } st_t;

    st_t st_q, st_d;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic              mem_wr   [DEPTH];
    logic              mem_rd   [DEPTH];

    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   cnt_q;
    logic [15:0]   drop_q;

    logic lo_ok, hi_ok, hit;
    logic full, pop, cap, push, ovr, stop_evt, drop_ev, wen;

    // Window edges at the extremes of the address space need no compare
    if (WIN_LO == '0) begin : g_lo_open
        assign lo_ok = 1'b1;
    end else begin : g_lo_cmp
        assign lo_ok = (addr >= WIN_LO);
    end

    if (WIN_HI == {ADDR_W{1'b1}}) begin : g_hi_open
        assign hi_ok = 1'b1;
    end else begin : g_hi_cmp
        assign hi_ok = (addr <= WIN_HI);
    end

    assign hit = (read | write) & lo_ok & hi_ok;

    assign full      = (cnt_q == FULL_N);
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid & out_ready & ~clear;
    assign cap       = (st_q == CAPTURE) & hit & ~clear;
    assign push      = cap & (~full | pop);
    assign ovr       = cap & full & ~pop & ~stop_on_full;
    assign stop_evt  = cap & full & ~pop & stop_on_full;
    assign drop_ev   = ovr | stop_evt
                     | ((st_q == STOPPED) & hit & ~clear);
    assign wen       = push | ovr;

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            IDLE: begin
                if (!disarm && arm) st_d = CAPTURE;
            end
            CAPTURE: begin
                if (disarm)        st_d = IDLE;
                else if (stop_evt) st_d = STOPPED;
            end
            STOPPED: begin
                if (disarm)                     st_d = IDLE;
                else if (clear || (arm && !full)) st_d = CAPTURE;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q <= IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            drop_q <= '0;
        end else if (clear) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            drop_q <= '0;
        end else begin
            if (wen)        wr_q <= wr_q + 1'b1;
            // An overwrite in wrap mode retires the oldest entry
            if (pop || ovr) rd_q <= rd_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
            if (drop_ev && drop_q != 16'hFFFF)
                drop_q <= drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wen) begin
            mem_addr[wr_q] <= addr;
            mem_data[wr_q] <= write ? wdata : rdata;
            mem_wr[wr_q]   <= write;
            mem_rd[wr_q]   <= read;
        end
    end

    assign out_wr   = mem_wr[rd_q];
    assign out_rd   = mem_rd[rd_q];
    assign out_addr = mem_addr[rd_q];
    assign out_data = mem_data[rd_q];
    assign count    = cnt_q;
    assign drop_cnt = drop_q;
    assign state    = st_q;

endmodule

// File: tb/tb_data_mem_trace.sv
// Bench for data_mem_trace: directed steps then random traffic,
// checked against a queue-based model of the trace buffer.
module tb_data_mem_trace;

    localparam logic [31:0] LO = 32'h10;
    localparam logic [31:0] HI = 32'h1FF;
    localparam int          DEP = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, rdata;
    logic        read, write, arm, disarm, clear, stop_on_full;
    logic        out_valid, out_ready, out_wr, out_rd;
    logic [31:0] out_addr, out_data;
    logic [4:0]  count;
    logic [15:0] drop_cnt;
    logic [1:0]  state;

    data_mem_trace #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(DEP),
        .WIN_LO(LO), .WIN_HI(HI)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .rdata(rdata), .read(read), .write(write), .arm(arm),
        .disarm(disarm), .clear(clear), .stop_on_full(stop_on_full),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wr(out_wr), .out_rd(out_rd), .out_addr(out_addr),
        .out_data(out_data), .count(count), .drop_cnt(drop_cnt),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    int   mst;
    int   mdrop;
    int   n_chk;
    int   n_fail;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bump_drop();
        if (mdrop < 65535) mdrop++;
    endtask

    // One clock of the reference: queue semantics from the access rules
    task automatic model_step();
        automatic bit   hit = (read || write) && addr >= LO && addr <= HI;
        automatic bit   was_full = (q.size() == DEP);
        automatic bit   popped = 0;
        automatic bit   stopnow = 0;
        automatic ent_t e;
        e.wr = write;
        e.rd = read;
        e.a  = addr;
        e.d  = write ? wdata : rdata;
        if (clear) begin
            q.delete();
            mdrop = 0;
            if (disarm)                mst = 0;
            else if (mst == 2)         mst = 1;
            else if (mst == 0 && arm)  mst = 1;
            return;
        end
        if (out_ready && q.size() > 0) begin
            void'(q.pop_front());
            popped = 1;
        end
        if (mst == 1 && hit) begin
            if (!was_full || popped) begin
                q.push_back(e);
            end else if (!stop_on_full) begin
                void'(q.pop_front());
                q.push_back(e);
                bump_drop();
            end else begin
                bump_drop();
                stopnow = 1;
            end
        end else if (mst == 2 && hit) begin
            bump_drop();
        end
        if (disarm)                           mst = 0;
        else if (mst == 0 && arm)             mst = 1;
        else if (mst == 1 && stopnow)         mst = 2;
        else if (mst == 2 && arm && !was_full) mst = 1;
    endtask

    task automatic check_all();
        chk("valid", out_valid, q.size() != 0);
        chk("count", count, q.size());
        chk("drop", drop_cnt, mdrop);
        chk("state", state, mst);
        if (q.size() != 0) begin
            chk("out_wr", out_wr, q[0].wr);
            chk("out_rd", out_rd, q[0].rd);
            chk("out_addr", out_addr, q[0].a);
            chk("out_data", out_data, q[0].d);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic quiet();
        read = 0; write = 0; arm = 0; disarm = 0; clear = 0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        quiet();
        write = 1; addr = a; wdata = d;
        tick();
        write = 0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        mst = 0; mdrop = 0;
        reset = 0;
        addr = 0; wdata = 0; rdata = 0;
        read = 0; write = 0; arm = 0; disarm = 0; clear = 0;
        stop_on_full = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1;

        // basic store then load, drained in order
        arm = 1; tick(); arm = 0;
        chk("t1_state", state, 1);
        store(32'h10, 32'hDEADBEEF);
        chk("t1_wr", out_wr, 1);
        chk("t1_addr0", out_addr, 32'h10);
        chk("t1_data0", out_data, 32'hDEADBEEF);
        read = 1; addr = 32'h14; rdata = 32'h5;
        tick(); read = 0;
        chk("t1_cnt2", count, 2);
        out_ready = 1;
        tick();
        chk("t1_rd", out_rd, 1);
        chk("t1_addr1", out_addr, 32'h14);
        chk("t1_data1", out_data, 32'h5);
        tick();
        out_ready = 0;
        chk("t1_cnt0", count, 0);
        chk("t1_drop", drop_cnt, 0);

        // address window edges
        store(32'h0C, 32'h1);
        store(32'h10, 32'h2);
        store(32'h1FF, 32'h3);
        store(32'h200, 32'h4);
        chk("t2_cnt", count, 2);
        chk("t2_head", out_addr, 32'h10);
        out_ready = 1; tick(); tick(); out_ready = 0;
        disarm = 1; tick(); disarm = 0;
        chk("t2_idle", state, 0);
        for (int i = 0; i < 3; i++) store(32'h40 + i, i);
        chk("t2_idle_cnt", count, 0);

        // wrap mode overwrite
        arm = 1; tick(); arm = 0;
        for (int i = 1; i <= 20; i++) store(32'h100 + 4 * i, i);
        chk("t3_cnt", count, 16);
        chk("t3_drop", drop_cnt, 4);
        out_ready = 1;
        for (int i = 0; i < 16; i++) begin
            chk("t3_order", out_data, 5 + i);
            tick();
        end
        out_ready = 0;
        chk("t3_empty", count, 0);
        clear = 1; tick(); clear = 0;
        chk("t3_clear", drop_cnt, 0);

        // stop-on-full
        stop_on_full = 1;
        for (int i = 1; i <= 18; i++) store(32'h80, i);
        chk("t4_cnt", count, 16);
        chk("t4_drop", drop_cnt, 2);
        chk("t4_stop", state, 2);
        out_ready = 1; tick(); out_ready = 0;
        chk("t4_still", state, 2);
        arm = 1; tick(); arm = 0;
        chk("t4_rearm", state, 1);
        store(32'h84, 32'h99);
        chk("t4_cnt16", count, 16);
        chk("t4_drop2", drop_cnt, 2);

        // full buffer with push and pop together
        chk("t5_head", out_data, 2);
        out_ready = 1;
        store(32'h88, 32'hAAAA);
        chk("t5_cnt", count, 16);
        chk("t5_nodrop", drop_cnt, 2);
        chk("t5_next", out_data, 3);
        for (int i = 0; i < 16; i++) tick();
        out_ready = 0;
        stop_on_full = 0;
        read = 1; write = 1; addr = 32'h40;
        wdata = 32'h1234; rdata = 32'h5678;
        tick(); quiet();
        chk("t5_rw_wr", out_wr, 1);
        chk("t5_rw_rd", out_rd, 1);
        chk("t5_rw_data", out_data, 32'h1234);

        // async reset mid-drain, then clear beating a store
        for (int i = 0; i < 7; i++) store(32'h20 + i, 32'h300 + i);
        out_ready = 1; tick();
        chk("t6_cnt7", count, 7);
        out_ready = 0;
        #2 reset = 0;
        #1;
        q.delete(); mdrop = 0; mst = 0;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_cnt", count, 0);
        check_all();
        reset = 1;
        arm = 1; tick(); arm = 0;
        store(32'h30, 32'h1);
        store(32'h34, 32'h2);
        write = 1; clear = 1; addr = 32'h38; wdata = 32'h3;
        tick(); quiet();
        chk("t6_clr_cnt", count, 0);
        chk("t6_clr_drop", drop_cnt, 0);

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            quiet();
            read   = ($urandom_range(9, 0) < 4);
            write  = ($urandom_range(9, 0) < 4);
            addr   = $urandom_range(32'h27F, 0);
            wdata  = $urandom;
            rdata  = $urandom;
            out_ready = ($urandom_range(2, 0) == 0);
            arm    = ($urandom_range(15, 0) == 0);
            disarm = ($urandom_range(40, 0) == 0);
            if (!arm && !disarm)
                clear = ($urandom_range(80, 0) == 0);
            if ($urandom_range(60, 0) == 0)
                stop_on_full = ~stop_on_full;
            tick();
        end
        quiet();
        out_ready = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
